test_logic: RTL and testbench

- Programmable 4-input Boolean function block.
- Output y = TT[{a,b,c,d}], where TT is a 16-entry truth table.
- TT resets to a parameterised default and can be reloaded at runtime.
- Provides a combinational output, a registered copy, edge pulses and a saturating high-cycle counter, for use as a small glue-logic or decision element.

---
 rtl/test_logic.sv | 89 ++++++++
 tb/tb_test_logic.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/test_logic.sv
// Programmable 4-input Boolean function block.
// A 16-entry truth table indexed by {a,b,c,d} drives the combinational result. Around it sit a
// registered copy of that result, single-cycle rise/fall pulses and a saturating counter of the
// cycles in which the result was high. The table can be reloaded at runtime.
module test_logic #(
  parameter logic [15:0] DEFAULT_TT = 16'hF888,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             c_i,
  input  logic             d_i,
  input  logic             cfg_we_i,
  input  logic [15:0]      cfg_tt_i,
  input  logic             cnt_clr_i,
  output logic             y_o,
  output logic             y_r_o,
  output logic             y_rise_o,
  output logic             y_fall_o,
  output logic [15:0]      tt_o,
  output logic [CNT_W-1:0] hi_cnt_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [3:0]       idx;
  logic [15:0]      tt_q;
  logic             y_r_q;
  logic             rise_q;
  logic             fall_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Table lookup; a is the MSB of the index.
  always_comb begin
    idx = {a_i, b_i, c_i, d_i};
    y_o = tt_q[idx];
  end

  // Truth-table storage. The new table takes effect only after the load edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tt_q <= DEFAULT_TT;
    end else if (cfg_we_i) begin
      tt_q <= cfg_tt_i;
    end
  end

  // Registered result and edge pulses. The pulses are aligned with the change of y_r_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      y_r_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      y_r_q  <= y_o;
      rise_q <= y_o & ~y_r_q;
      fall_q <= ~y_o & y_r_q;
    end
  end

  // Counter next state. A clear wins over an increment, and the count holds at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (y_o && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // High-cycle counter state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign y_r_o    = y_r_q;
  assign y_rise_o = rise_q;
  assign y_fall_o = fall_q;
  assign tt_o     = tt_q;
  assign hi_cnt_o = cnt_q;

endmodule

// File: tb/tb_test_logic.sv
// Self-checking bench for test_logic: directed plan steps followed by random traffic, all
// compared against a behavioural model kept in plain integers.
module tb_test_logic;

  localparam int CntW = 8;
  localparam int CntMax = (1 << CntW) - 1;

  logic            clk;
  logic            rst;
  logic            a, b, c, d;
  logic            cfg_we;
  logic [15:0]     cfg_tt;
  logic            cnt_clr;
  logic            y, y_r, y_rise, y_fall;
  logic [15:0]     tt;
  logic [CntW-1:0] hi_cnt;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  int m_tt;
  int m_yr;
  int m_rise;
  int m_fall;
  int m_cnt;

  test_logic #(
    .DEFAULT_TT(16'hF888),
    .CNT_W     (CntW)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .a_i      (a),
    .b_i      (b),
    .c_i      (c),
    .d_i      (d),
    .cfg_we_i (cfg_we),
    .cfg_tt_i (cfg_tt),
    .cnt_clr_i(cnt_clr),
    .y_o      (y),
    .y_r_o    (y_r),
    .y_rise_o (y_rise),
    .y_fall_o (y_fall),
    .tt_o     (tt),
    .hi_cnt_o (hi_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_y(input int table_v, input int i);
    return (table_v >> i) & 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tt = 16'hF888; m_yr = 0; m_rise = 0; m_fall = 0; m_cnt = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".y_r"}, 32'(y_r), 32'(m_yr));
    check({tag, ".rise"}, 32'(y_rise), 32'(m_rise));
    check({tag, ".fall"}, 32'(y_fall), 32'(m_fall));
    check({tag, ".cnt"}, 32'(hi_cnt), 32'(m_cnt));
    check({tag, ".tt"}, 32'(tt), 32'(m_tt));
    check({tag, ".pulse_excl"}, 32'(y_rise & y_fall), 32'd0);
  endtask

  // One clock cycle: drive inputs, check the combinational result on the current table,
  // advance the model across the edge, then check the registered state and the new table.
  task automatic step(input string tag, input int i, input logic we, input logic [15:0] cfg,
                      input logic clr);
    int yv;
    {a, b, c, d} = 4'(i);
    cfg_we = we; cfg_tt = cfg; cnt_clr = clr;
    #1;
    yv = model_y(m_tt, i);
    check({tag, ".y_pre"}, 32'(y), 32'(yv));
    @(posedge clk);
    m_rise = (yv == 1 && m_yr == 0) ? 1 : 0;
    m_fall = (yv == 0 && m_yr == 1) ? 1 : 0;
    m_yr = yv;
    if (clr) m_cnt = 0;
    else if (yv == 1 && m_cnt < CntMax) m_cnt = m_cnt + 1;
    if (we) m_tt = int'(cfg);
    #1;
    cfg_we = 1'b0; cnt_clr = 1'b0;
    check_regs(tag);
    check({tag, ".y_post"}, 32'(y), 32'(model_y(m_tt, i)));
  endtask

  initial begin
    rst = 1'b1;
    {a, b, c, d} = 4'd0;
    cfg_we = 1'b0; cfg_tt = 16'h0; cnt_clr = 1'b0;
    model_reset();
    #1;
    check_regs("reset");
    check("reset.y", 32'(y), 32'd0);
    #2 rst = 1'b0;

    // Default table: y = (a&b)|(c&d), high exactly for 3,7,11,12..15.
    for (int i = 0; i < 16; i++) begin
      int exp_y;
      exp_y = (i == 3 || i == 7 || i == 11 || i >= 12) ? 1 : 0;
      {a, b, c, d} = 4'(i);
      #1;
      check("default.y_direct", 32'(y), 32'(exp_y));
      step("default", i, 1'b0, 16'h0, 1'b0);
    end

    // Load XOR4; the load cycle still sees the old table (i=3 -> 1 old, 0 new).
    step("load_xor", 3, 1'b1, 16'h6996, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step("xor", i, 1'b0, 16'h0, 1'b0);
      check("xor.parity", 32'(y), 32'($countones(4'(i)) & 1));
    end

    // Toggle 0 <-> 15 on the default table to exercise the pulses.
    step("restore", 0, 1'b1, 16'hF888, 1'b0);
    for (int k = 0; k < 8; k++) step("toggle", (k % 2 == 0) ? 15 : 0, 1'b0, 16'h0, 1'b0);
    step("hold_hi", 15, 1'b0, 16'h0, 1'b0);
    step("hold_hi", 15, 1'b0, 16'h0, 1'b0);

    // Saturation: clear first, then 300 high cycles.
    step("clr", 15, 1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 300; k++) step("sat", 15, 1'b0, 16'h0, 1'b0);
    check("sat.value", 32'(hi_cnt), 32'd255);
    step("clr_vs_inc", 15, 1'b0, 16'h0, 1'b1);
    check("clr_vs_inc.value", 32'(hi_cnt), 32'd0);

    // Random traffic.
    for (int k = 0; k < 250; k++) begin
      logic we;
      logic clr;
      we  = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step("rand", int'($urandom_range(0, 15)), we, 16'($urandom), clr);
    end

    // Asynchronous reset between edges with an all-zero table loaded.
    step("load_zero", 12, 1'b1, 16'h0000, 1'b0);
    step("zero", 12, 1'b0, 16'h0, 1'b0);
    check("zero.y", 32'(y), 32'd0);
    #3 rst = 1'b1;
    model_reset();
    #1;
    check_regs("async_rst");
    check("async_rst.y12", 32'(y), 32'd1);
    @(posedge clk);
    #1;
    check_regs("rst_held");
    rst = 1'b0;
    for (int k = 0; k < 4; k++) step("after_rst", (k % 2 == 0) ? 12 : 1, 1'b0, 16'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
